// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants and state type for the SPI flash RDID master
package spi_flash_pkg;

  localparam logic [7:0] RDID_OPCODE = 8'h9F;
  localparam int         CMD_BITS    = 8;
  localparam int         RESP_BITS   = 24;
  localparam int         ID_BITS     = 8;
  localparam int         BIT_CNT_W   = 5;

  // Bit index where MISO capture begins, the final bit of the frame, and the counter step.
  localparam logic [BIT_CNT_W-1:0] CNT_RESP_START = 5'd8;
  localparam logic [BIT_CNT_W-1:0] CNT_LAST_BIT   = 5'd31;
  localparam logic [BIT_CNT_W-1:0] CNT_STEP       = 5'd1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    SHIFT    = 2'd2,
    DESELECT = 2'd3
  } state_t;

endpackage

// File: rtl/spi_clk_shifter.sv
// rtl/spi_clk_shifter.sv - SPICLK generation, bit counter and MOSI/MISO shifting
module spi_clk_shifter
  import spi_flash_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_select,
  input  logic                 i_shift,
  input  logic                 i_miso,
  output logic                 o_sclk,
  output logic                 o_mosi,
  output logic                 o_last_rise,
  output logic                 o_last_fall,
  output logic [RESP_BITS-1:0] o_rx_word
);

  logic [CMD_BITS-1:0]  r_tx;
  logic [RESP_BITS-1:0] r_rx;
  logic [BIT_CNT_W-1:0] r_count;
  logic                 r_sclk;
  logic                 r_mosi;

  // SPICLK toggles every clk in SHIFT; MISO captured on rising, MOSI advanced on falling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx    <= '0;
      r_rx    <= '0;
      r_count <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else if (i_load) begin
      r_tx    <= RDID_OPCODE;
      r_count <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else if (i_select) begin
      r_mosi <= r_tx[CMD_BITS-1];
      r_tx   <= {r_tx[CMD_BITS-2:0], 1'b0};
    end else if (i_shift) begin
      if (!r_sclk) begin
        r_sclk <= 1'b1;
        if (r_count >= CNT_RESP_START) begin
          r_rx <= {r_rx[RESP_BITS-2:0], i_miso};
        end
      end else begin
        r_sclk  <= 1'b0;
        r_mosi  <= r_tx[CMD_BITS-1];
        r_tx    <= {r_tx[CMD_BITS-2:0], 1'b0};
        r_count <= r_count + CNT_STEP;
      end
    end else begin
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
    end
  end

  assign o_sclk      = r_sclk;
  assign o_mosi      = r_mosi;
  assign o_last_rise = i_shift & ~r_sclk & (r_count == CNT_LAST_BIT);
  assign o_last_fall = i_shift &  r_sclk & (r_count == CNT_LAST_BIT);
  // Full word including the bit being sampled on this rising edge.
  assign o_rx_word   = {r_rx[RESP_BITS-2:0], i_miso};

endmodule

// File: rtl/spi_rdid_master.sv
// rtl/spi_rdid_master.sv - SPI mode-0 master issuing RDID and capturing the 24-bit JEDEC ID
module spi_rdid_master
  import spi_flash_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 get_rdid,
  output logic                 SPICLK,
  output logic                 SPIMOSI,
  input  logic                 SPIMISO,
  output logic                 chip_select,
  output logic                 busy,
  output logic                 rdid_done,
  output logic [RESP_BITS-1:0] read_data,
  output logic [ID_BITS-1:0]   manufacture_id,
  output logic [ID_BITS-1:0]   memory_type,
  output logic [ID_BITS-1:0]   memory_capacity
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_cs;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_cs_next;
  logic                 w_busy_next;
  logic                 w_done_next;
  logic [RESP_BITS-1:0] r_read_data;

  logic                 w_load;
  logic                 w_last_rise;
  logic                 w_last_fall;
  logic [RESP_BITS-1:0] w_rx_word;

  assign w_load = (r_state == IDLE) & get_rdid;

  spi_clk_shifter u_shifter (
    .clk         (clk),
    .rst         (reset),
    .i_load      (w_load),
    .i_select    (r_state == SELECT),
    .i_shift     (r_state == SHIFT),
    .i_miso      (SPIMISO),
    .o_sclk      (SPICLK),
    .o_mosi      (SPIMOSI),
    .o_last_rise (w_last_rise),
    .o_last_fall (w_last_fall),
    .o_rx_word   (w_rx_word)
  );

  // State and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cs    <= w_cs_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and next-output decode for the transaction sequence.
  always_comb begin
    w_state_next = r_state;
    w_cs_next    = r_cs;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (get_rdid) begin
          w_state_next = SELECT;
          w_busy_next  = 1'b1;
        end
      end
      SELECT: begin
        w_cs_next    = 1'b0;
        w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_last_fall) begin
          w_done_next  = 1'b1;
          w_state_next = DESELECT;
        end
      end
      DESELECT: begin
        w_cs_next    = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Result register loads on the final rising SPICLK edge and holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_data <= '0;
    end else if (w_last_rise) begin
      r_read_data <= w_rx_word;
    end
  end

  assign chip_select     = r_cs;
  assign busy            = r_busy;
  assign rdid_done       = r_done;
  assign read_data       = r_read_data;
  assign manufacture_id  = r_read_data[23:16];
  assign memory_type     = r_read_data[15:8];
  assign memory_capacity = r_read_data[7:0];

endmodule

// File: tb/tb_spi_rdid_master.sv
// tb/tb_spi_rdid_master.sv - directed self-checking bench for spi_rdid_master
module tb_spi_rdid_master;

  logic        clk;
  logic        reset;
  logic        get_rdid;
  logic        SPICLK;
  logic        SPIMOSI;
  logic        SPIMISO;
  logic        chip_select;
  logic        busy;
  logic        rdid_done;
  logic [23:0] read_data;
  logic [7:0]  manufacture_id;
  logic [7:0]  memory_type;
  logic [7:0]  memory_capacity;

  int          checks   = 0;
  int          failures = 0;
  int          edges    = 0;
  int          stray    = 0;
  int          done_cnt = 0;
  int          fbit     = 0;
  logic [23:0] flash_id = 24'h202015;
  logic [7:0]  opcode   = 8'h9F;

  spi_rdid_master dut (
    .clk             (clk),
    .reset           (reset),
    .get_rdid        (get_rdid),
    .SPICLK          (SPICLK),
    .SPIMOSI         (SPIMOSI),
    .SPIMISO         (SPIMISO),
    .chip_select     (chip_select),
    .busy            (busy),
    .rdid_done       (rdid_done),
    .read_data       (read_data),
    .manufacture_id  (manufacture_id),
    .memory_type     (memory_type),
    .memory_capacity (memory_capacity)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Flash model: bit index advances on each falling SPICLK while selected.
  always @(negedge SPICLK or posedge chip_select) begin
    if (chip_select) fbit = 0;
    else             fbit = fbit + 1;
  end
  assign SPIMISO = (fbit >= 8 && fbit < 32) ? flash_id[31 - fbit] : 1'b0;

  // SPICLK rising edge counters.
  always @(posedge SPICLK) begin
    edges = edges + 1;
    if (chip_select) stray = stray + 1;
  end

  // rdid_done high-cycle counter.
  always @(posedge clk) begin
    if (rdid_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string nm, input logic [23:0] exp_id, input bit poke_mid);
    int sclk_bad;
    int mosi_bad;
    sclk_bad = 0;
    mosi_bad = 0;
    @(negedge clk);
    edges    = 0;
    done_cnt = 0;
    get_rdid = 1'b1;
    @(negedge clk);
    get_rdid = 1'b0;
    check({nm, "_busy_T"}, 24'(busy), 24'd1);
    for (int n = 1; n <= 66; n++) begin
      @(negedge clk);
      if (poke_mid) get_rdid = (n == 20);
      if (n == 1) begin
        check({nm, "_cs_T1"}, 24'(chip_select), 24'd0);
        check({nm, "_sclk_T1"}, 24'(SPICLK), 24'd0);
      end
      if (n >= 2 && n <= 65 && SPICLK !== ((n % 2) == 0)) sclk_bad++;
      if (n >= 2 && n <= 16 && (n % 2) == 0)
        check({nm, "_mosi_op"}, 24'(SPIMOSI), 24'(opcode[7 - (n - 2) / 2]));
      if (n >= 18 && n <= 64 && (n % 2) == 0 && SPIMOSI !== 1'b0) mosi_bad++;
      if (n == 64) check({nm, "_rd_T64"}, read_data, exp_id);
      if (n == 65) begin
        check({nm, "_done_T65"}, 24'(rdid_done), 24'd1);
        check({nm, "_edges"}, 24'(edges), 24'd32);
        check({nm, "_rd"}, read_data, exp_id);
        check({nm, "_mid"}, 24'(manufacture_id), 24'(exp_id[23:16]));
        check({nm, "_mtype"}, 24'(memory_type), 24'(exp_id[15:8]));
        check({nm, "_mcap"}, 24'(memory_capacity), 24'(exp_id[7:0]));
        check({nm, "_cs_T65"}, 24'(chip_select), 24'd0);
      end
      if (n == 66) begin
        check({nm, "_cs_T66"}, 24'(chip_select), 24'd1);
        check({nm, "_busy_T66"}, 24'(busy), 24'd0);
        check({nm, "_done_T66"}, 24'(rdid_done), 24'd0);
      end
    end
    check({nm, "_sclk_pattern"}, 24'(sclk_bad), 24'd0);
    check({nm, "_mosi_zero"}, 24'(mosi_bad), 24'd0);
    check({nm, "_done_once"}, 24'(done_cnt), 24'd1);
    check({nm, "_edges_final"}, 24'(edges), 24'd32);
  endtask

  initial begin
    int idle_bad;
    reset    = 1'b1;
    get_rdid = 1'b0;
    #100;
    @(negedge clk);
    check("rst_cs", 24'(chip_select), 24'd1);
    check("rst_sclk", 24'(SPICLK), 24'd0);
    check("rst_mosi", 24'(SPIMOSI), 24'd0);
    check("rst_busy", 24'(busy), 24'd0);
    check("rst_done", 24'(rdid_done), 24'd0);
    check("rst_rd", read_data, 24'h000000);
    reset = 1'b0;

    run_txn("t1", 24'h202015, 1'b0);
    run_txn("t2", 24'h202015, 1'b0);

    flash_id = 24'hA5C33C;
    run_txn("t3poke", 24'hA5C33C, 1'b1);
    check("t3_busy_after", 24'(busy), 24'd0);

    // Abort at T+20 with reset, then a clean transaction.
    flash_id = 24'h202015;
    @(negedge clk);
    get_rdid = 1'b1;
    @(negedge clk);
    get_rdid = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_cs", 24'(chip_select), 24'd1);
    check("abort_sclk", 24'(SPICLK), 24'd0);
    check("abort_mosi", 24'(SPIMOSI), 24'd0);
    check("abort_busy", 24'(busy), 24'd0);
    check("abort_rd", read_data, 24'h000000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_txn("t4", 24'h202015, 1'b0);

    // Idle: no SPICLK activity and chip select held high.
    idle_bad = 0;
    edges    = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (chip_select !== 1'b1 || SPICLK !== 1'b0 || busy !== 1'b0) idle_bad++;
    end
    check("idle_static", 24'(idle_bad), 24'd0);
    check("idle_edges", 24'(edges), 24'd0);
    check("stray_edges", 24'(stray), 24'd0);
    check("idle_rd_hold", read_data, 24'h202015);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
